usb_tx_arbiter: RTL and testbench
=================================

Name: usb_tx_arbiter

Overview:
- Shares the single FT245 synchronous-FIFO write port between two framed byte streams: FFT result frames (src 0) and raw FIR sample frames for debug (src 1).
- Arbitration is frame-atomic. A granted source keeps the port until its last byte.
- A registered one-entry output stage holds any byte the FT245 refuses, so no byte is lost.
- tx_idle feeds the sequencing control block, which waits on it before starting the next acquisition.

Parameters:
- DATA_W, 8, byte width of the FT245 data bus and of both source streams.
- CTR_W, 8, width of the frame sequence counter carried in the optional header.

Ports:
- clk  in  1  system clock (FT245 60 MHz sync clock domain)
- rst_n  in  1  reset, asynchronous, active-low
- fft_data  in  DATA_W  src 0 byte
- fft_valid  in  1  src 0 byte valid
- fft_last  in  1  src 0 final byte of frame, qualified by fft_valid
- fft_ready  out  1  src 0 byte accepted this cycle when fft_valid && fft_ready
- raw_data  in  DATA_W  src 1 byte
- raw_valid  in  1  src 1 byte valid
- raw_last  in  1  src 1 final byte of frame
- raw_ready  out  1  src 1 accept
- ft_txe_n  in  1  FT245 TX FIFO has space when low
- ft_wr_n  out  1  FT245 write strobe, active-low, registered
- ft_data  out  DATA_W  FT245 write data, registered
- tx_idle  out  1  high in IDLE with ft_wr_n high (nothing pending)
- frame_done  out  1  one-cycle pulse after a frame's last byte is taken by the FT245

Behaviour:
- Reset values: ft_wr_n=1, ft_data=0, tx_idle=1, frame_done=0. Counter, grant and last_grant are 0. State is IDLE. Ready outputs are 0 while rst_n is low.
- Reset asserted mid-frame: the frame is abandoned and any held byte is discarded. Sources are reset on the same rst_n.

Output stage:
- An FT245 transfer completes at a rising edge where ft_wr_n==0 && ft_txe_n==0.
- space = ft_wr_n || !ft_txe_n.
- When space is high and a byte is supplied: load ft_data and set ft_wr_n=0.
- When space is high and no byte is supplied: set ft_wr_n=1.
- When ft_wr_n==0 && ft_txe_n==1: hold ft_data and ft_wr_n unchanged. The byte is retried.
- Latency from source accept to ft_wr_n low is 1 cycle.

State machine:
- IDLE:
  - Only fft_valid high: grant=0.
  - Only raw_valid high: grant=1.
  - Both high in the same cycle: grant = !last_grant (alternating fairness).
  - Next state is HDR if USB_TX_HEADER_EN is defined, else XFER.
  - No byte is accepted in IDLE.
- HDR: emits 4 bytes through the output stage, one per cycle with space:
  - 0x5A
  - 0xA5
  - source id: 0x01 for FFT, 0x02 for raw
  - frame counter low byte
  - Then goes to XFER.
- XFER:
  - Granted ready = space. The other ready = 0.
  - An accepted byte is loaded into the output stage.
  - Accepting with last=1 moves to DRAIN. last_grant <= grant, and the frame counter increments (wraps from 2^CTR_W-1 to 0).
- DRAIN: waits until the last byte completes (ft_wr_n==0 && ft_txe_n==0). Then pulses frame_done for 1 cycle and returns to IDLE.
- Arbitration is re-evaluated only in IDLE. A request arriving mid-frame waits.
- Minimum IDLE dwell between frames is 1 cycle.
- A source dropping valid mid-frame stalls XFER; there is no timeout.
- fft_last/raw_last seen on a non-granted source are ignored.
- Illegal state goes to IDLE, with ft_wr_n forced to 1.
- tx_idle = (state==IDLE) && ft_wr_n.

Optional Feature:
- Macro: USB_TX_HEADER_EN.
- Defined: the 4-byte header above precedes every frame, and the frame counter is instantiated.
- Undefined: no HDR state; IDLE goes directly to XFER. The counter is removed, and the output stream is the raw concatenation of frames.

Test Plan:
- Reset, then ft_txe_n=0 and a 4-byte FFT frame 0x10..0x13 with last on 0x13. Required:
  - Header undefined: ft_data 0x10,0x11,0x12,0x13 on consecutive ft_wr_n-low cycles; frame_done pulses once; tx_idle returns to 1.
  - Header defined: 0x5A,0xA5,0x01,0x00 precede the payload.
- fft_valid and raw_valid asserted in the same cycle, three times with last_grant=0 after reset. Required: grant order raw, FFT, raw; frames never interleave.
- ft_txe_n held high for 5 cycles while ft_wr_n=0 holding byte 0x22. Required: ft_data stays 0x22 and the ready outputs stay 0; after release 0x22 is written exactly once and the next byte follows.
- raw_valid rises mid-FFT-frame. Required: raw_ready stays 0 until the FFT frame_done; raw is then granted from IDLE.
- 257 frames with the header enabled. Required: the counter byte goes 0x00..0xFF, then 0x00.
- rst_n pulsed low asynchronously mid-frame between clock edges. Required: ft_wr_n=1 immediately, state IDLE, tx_idle=1, and the counter at 0 after release.

Source files
------------

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: frame-atomic arbiter sharing the FT245 sync-FIFO write port between two byte streams
// Build option: define USB_TX_HEADER_EN to prefix every frame with 5A A5 <src id> <frame counter low byte>.
// Ports:
//   clk, rst_n           FT245 60 MHz clock, asynchronous active-low reset
//   fft_data/valid/last  src 0 byte stream (FFT result frames), fft_ready accepts
//   raw_data/valid/last  src 1 byte stream (raw FIR debug frames), raw_ready accepts
//   ft_txe_n             FT245 TX FIFO has space when low
//   ft_wr_n, ft_data     registered FT245 write strobe (active-low) and data
//   tx_idle              high in IDLE with no byte pending
//   frame_done           one-cycle pulse after a frame's last byte is taken by the FT245
module usb_tx_arbiter #(
    parameter int DATA_W = 8,
    parameter int CTR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] fft_data,
    input  logic              fft_valid,
    input  logic              fft_last,
    output logic              fft_ready,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              raw_valid,
    input  logic              raw_last,
    output logic              raw_ready,
    input  logic              ft_txe_n,
    output logic              ft_wr_n,
    output logic [DATA_W-1:0] ft_data,
    output logic              tx_idle,
    output logic              frame_done
);
    typedef enum logic [1:0] {IDLE, HDR, XFER, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d, last_grant_q, last_grant_d;
    logic              wr_n_q, wr_n_d, done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d, byte_d, sel_data;
    logic              load, space, sel_valid, sel_last, force_idle;
`ifdef USB_TX_HEADER_EN
    logic [1:0]        hcnt_q, hcnt_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [DATA_W-1:0] hdr_byte;
`endif

    // The output register can take a new byte when empty or when its byte leaves this edge.
    assign space      = wr_n_q | ~ft_txe_n;
    assign sel_valid  = grant_q ? raw_valid : fft_valid;
    assign sel_last   = grant_q ? raw_last  : fft_last;
    assign sel_data   = grant_q ? raw_data  : fft_data;
    assign ft_wr_n    = wr_n_q;
    assign ft_data    = data_q;
    assign frame_done = done_q;
    assign tx_idle    = (state_q == IDLE) && wr_n_q;
`ifdef USB_TX_HEADER_EN
    assign hdr_byte = (hcnt_q == 2'd0) ? DATA_W'(8'h5A) :
                      (hcnt_q == 2'd1) ? DATA_W'(8'hA5) :
                      (hcnt_q == 2'd2) ? (grant_q ? DATA_W'(8'h02) : DATA_W'(8'h01)) :
                      DATA_W'(ctr_q);
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        byte_d       = sel_data;
        done_d       = 1'b0;
        force_idle   = 1'b0;
        fft_ready    = 1'b0;
        raw_ready    = 1'b0;
`ifdef USB_TX_HEADER_EN
        hcnt_d       = hcnt_q;
        ctr_d        = ctr_q;
`endif
        case (state_q)
            IDLE: if (fft_valid || raw_valid) begin
                // Simultaneous requests alternate against the previous winner.
                grant_d = (fft_valid && raw_valid) ? ~last_grant_q : raw_valid;
`ifdef USB_TX_HEADER_EN
                hcnt_d  = 2'd0;
                state_d = HDR;
`else
                state_d = XFER;
`endif
            end
`ifdef USB_TX_HEADER_EN
            HDR: if (space) begin
                load    = 1'b1;
                byte_d  = hdr_byte;
                hcnt_d  = hcnt_q + 2'd1;
                state_d = (hcnt_q == 2'd3) ? XFER : HDR;
            end
`endif
            XFER: begin
                fft_ready = ~grant_q & space;
                raw_ready = grant_q & space;
                if (space && sel_valid) begin
                    load = 1'b1;
                    if (sel_last) begin
                        state_d      = DRAIN;
                        last_grant_d = grant_q;
`ifdef USB_TX_HEADER_EN
                        ctr_d        = ctr_q + CTR_W'(1);
`endif
                    end
                end
            end
            DRAIN: if (!wr_n_q && !ft_txe_n) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                force_idle = 1'b1;
            end
        endcase
        // A refused byte (strobe low, FIFO full) keeps strobe and data until it is taken.
        wr_n_d = force_idle ? 1'b1 : (space ? ~load : wr_n_q);
        data_d = load ? byte_d : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            wr_n_q       <= 1'b1;
            data_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_n_q       <= wr_n_d;
            data_q       <= data_d;
            done_q       <= done_d;
        end
    end

`ifdef USB_TX_HEADER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= 2'd0;
            ctr_q  <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            ctr_q  <= ctr_d;
        end
    end
`endif
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: table-driven and directed checks of the FT245 transmit arbiter (header-aware)
module tb_usb_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] fft_data = '0, raw_data = '0;
    logic       fft_valid = 1'b0, fft_last = 1'b0, raw_valid = 1'b0, raw_last = 1'b0;
    logic       ft_txe_n = 1'b0;
    logic       fft_ready, raw_ready, ft_wr_n, tx_idle, frame_done;
    logic [7:0] ft_data;

    usb_tx_arbiter #(.DATA_W(8), .CTR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .fft_data(fft_data), .fft_valid(fft_valid), .fft_last(fft_last), .fft_ready(fft_ready),
        .raw_data(raw_data), .raw_valid(raw_valid), .raw_last(raw_last), .raw_ready(raw_ready),
        .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n), .ft_data(ft_data),
        .tx_idle(tx_idle), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] order;
        int         nslots;
        logic [7:0] fbase;
        logic [7:0] rbase;
        int         len;
        int         nf;
        int         nr;
    } vec_t;

    vec_t       tbl[4];
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int         tests = 0, errors = 0, fd_cnt = 0, fd0, bad, scnt, fi, ri;
    bit         seen;
`ifdef USB_TX_HEADER_EN
    logic [7:0] hdr_ctr = 8'h00;
`endif

    // A byte is counted as written when the strobe is low and the FIFO has space at the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!ft_wr_n && !ft_txe_n) obs_q.push_back(ft_data);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_src(input bit src, input logic [7:0] d, input logic l, input logic v);
        if (src) begin
            raw_data = d; raw_last = l; raw_valid = v;
        end else begin
            fft_data = d; fft_last = l; fft_valid = v;
        end
    endtask

    task automatic drive(input bit src, input logic [7:0] base, input int nfr, input int len);
        bit acc;
        int cyc;
        for (int f = 0; f < nfr; f++) begin
            for (int i = 0; i < len; i++) begin
                acc = 1'b0;
                cyc = 0;
                set_src(src, base + 8'(f * len + i), i == len - 1, 1'b1);
                while (!acc) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        set_src(src, 8'h00, 1'b0, 1'b0);
                        return;
                    end
                    acc = src ? raw_ready : fft_ready;
                    cyc++;
                    if (cyc > 300) begin
                        tests++;
                        errors++;
                        $display("FAIL drive_timeout src=%0d: got no ready in 300 cycles, expected accept", src);
                        set_src(src, 8'h00, 1'b0, 1'b0);
                        return;
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
        set_src(src, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic exp_frame(input bit src, input logic [7:0] base, input int idx, input int len);
`ifdef USB_TX_HEADER_EN
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        exp_q.push_back(src ? 8'h02 : 8'h01);
        exp_q.push_back(hdr_ctr);
        hdr_ctr++;
`endif
        for (int i = 0; i < len; i++) exp_q.push_back(base + 8'(idx * len + i));
    endtask

    task automatic check_stream(input string name);
        chk({name, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), obs_q[i], exp_q[i]);
            if (obs_q[i] !== exp_q[i]) break;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (!tx_idle && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_reached", tx_idle, 1);
    endtask

    initial begin
        tbl[0] = '{order: 4'b0000, nslots: 1, fbase: 8'h10, rbase: 8'h00, len: 4, nf: 1, nr: 0};
        tbl[1] = '{order: 4'b0101, nslots: 4, fbase: 8'h40, rbase: 8'h80, len: 3, nf: 2, nr: 2};
        tbl[2] = '{order: 4'b0001, nslots: 1, fbase: 8'h00, rbase: 8'hC0, len: 2, nf: 0, nr: 1};
        tbl[3] = '{order: 4'b0010, nslots: 2, fbase: 8'h60, rbase: 8'hE0, len: 2, nf: 1, nr: 1};

        #2 rst_n = 1'b0;
        fft_valid = 1'b1;
        raw_valid = 1'b1;
        #10;
        chk("reset_wr_n", ft_wr_n, 1);
        chk("reset_ft_data", ft_data, 0);
        chk("reset_tx_idle", tx_idle, 1);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_fft_ready", fft_ready, 0);
        chk("reset_raw_ready", raw_ready, 0);
        fft_valid = 1'b0;
        raw_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();

        for (int v = 0; v < 4; v++) begin
            fd0 = fd_cnt;
            fork
                drive(1'b0, tbl[v].fbase, tbl[v].nf, tbl[v].len);
                drive(1'b1, tbl[v].rbase, tbl[v].nr, tbl[v].len);
            join
            wait_idle();
            fi = 0;
            ri = 0;
            for (int k = 0; k < tbl[v].nslots; k++) begin
                if (tbl[v].order[k]) begin
                    exp_frame(1'b1, tbl[v].rbase, ri, tbl[v].len);
                    ri++;
                end else begin
                    exp_frame(1'b0, tbl[v].fbase, fi, tbl[v].len);
                    fi++;
                end
            end
            check_stream($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_frame_done", v), fd_cnt - fd0, tbl[v].nslots);
        end

        // FIFO full for 5 cycles while 0x22 sits in the output register.
        fd0 = fd_cnt;
        bad = 0;
        scnt = 0;
        fork
            drive(1'b0, 8'h21, 1, 3);
            begin
                for (int c = 0; c < 100 && scnt < 5; c++) begin
                    if (!ft_wr_n && ft_data == 8'h22) begin
                        ft_txe_n = 1'b1;
                        scnt++;
                        @(negedge clk);
                        if (ft_data != 8'h22 || ft_wr_n || fft_ready || raw_ready) bad++;
                    end else begin
                        ft_txe_n = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                end
                ft_txe_n = 1'b0;
            end
        join
        wait_idle();
        chk("stall_cycles", scnt, 5);
        chk("stall_hold_bad_cycles", bad, 0);
        exp_frame(1'b0, 8'h21, 0, 3);
        check_stream("stall");
        chk("stall_frame_done", fd_cnt - fd0, 1);

        // Raw request arriving in the middle of an FFT frame waits for frame_done.
        fd0 = fd_cnt;
        bad = 0;
        seen = 1'b0;
        fork
            drive(1'b0, 8'h30, 1, 6);
            begin
                repeat (3) @(posedge clk);
                #1;
                drive(1'b1, 8'h50, 1, 2);
            end
            begin
                for (int c = 0; c < 300 && !seen; c++) begin
                    @(negedge clk);
                    if (frame_done) seen = 1'b1;
                    else if (raw_ready) bad++;
                end
            end
        join
        wait_idle();
        chk("midframe_fft_done_seen", seen, 1);
        chk("midframe_raw_ready_early", bad, 0);
        exp_frame(1'b0, 8'h30, 0, 6);
        exp_frame(1'b1, 8'h50, 0, 2);
        check_stream("midframe");
        chk("midframe_frame_done", fd_cnt - fd0, 2);

        // Asynchronous reset between clock edges in the middle of a frame.
        fork
            drive(1'b0, 8'h70, 1, 8);
            begin
                repeat (4) @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                chk("async_rst_wr_n", ft_wr_n, 1);
                chk("async_rst_tx_idle", tx_idle, 1);
                chk("async_rst_ft_data", ft_data, 0);
                chk("async_rst_frame_done", frame_done, 0);
                chk("async_rst_fft_ready", fft_ready, 0);
            end
        join
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
`ifdef USB_TX_HEADER_EN
        hdr_ctr = 8'h00;
        drive(1'b0, 8'h00, 257, 1);
        wait_idle();
        for (int j = 0; j < 257; j++) exp_frame(1'b0, 8'h00, j, 1);
        check_stream("post_reset_257");
        chk("post_reset_frame_done", fd_cnt - fd0, 257);
`else
        drive(1'b0, 8'h90, 1, 4);
        wait_idle();
        exp_frame(1'b0, 8'h90, 0, 4);
        check_stream("post_reset");
        chk("post_reset_frame_done", fd_cnt - fd0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
        $finish;
    end
endmodule
